uart_tx_periph: RTL and testbench

- UART transmitter slave on the processor's 8-bit peripheral bus (address, write data, read data, write strobe, read strobe).
- Processor writes bytes to a data register. Bytes queue in a small FIFO and are serialised 8N1, LSB first, on o_tx.
- A status register lets firmware poll busy/full/empty.
- Sits directly downstream of the processor's peripheral port. Clocked at the system 12 MHz clock.

---
 rtl/uart_tx_periph.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_periph.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// UART 8N1 transmitter on the 8-bit peripheral bus: data register feeds a TX FIFO, status register at BASE_ADDR+1.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing, status bit4 set).
module uart_tx_periph #(
  parameter logic [7:0] BASE_ADDR    = 8'h10,
  parameter int         CLKS_PER_BIT = 104,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_peripAddr,
  input  logic [7:0] i_peripDataFromCPU,
  input  logic       i_peripWrSig,
  input  logic       i_peripRdSig,
  output logic [7:0] o_peripDataToCPU,
  output logic       o_tx,
  output logic       o_irq
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'd1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_CAP = 1'b1;
`else
  localparam logic PAR_CAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t      state;
  logic [15:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_bit;
  logic        overflow;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        full;
  logic        empty;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        baud_done;
  logic [7:0]  head;
  logic [7:0]  status;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign push_req  = i_peripWrSig && (i_peripAddr == BASE_ADDR);
  assign baud_done = (baud == BAUD_LAST);
  // The FSM pops on leaving IDLE or at the end of STOP; a pop frees a slot for a same-cycle push when full.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
  assign push      = push_req && (!full || pop);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign status    = {3'b000, PAR_CAP, overflow, empty, full, (state != IDLE)};

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_peripDataFromCPU;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      overflow         <= 1'b0;
      o_peripDataToCPU <= 8'h00;
      o_irq            <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push)
        overflow <= 1'b1;
      else if (i_peripWrSig && (i_peripAddr == STAT_ADDR))
        overflow <= 1'b0;
      o_peripDataToCPU <= (i_peripRdSig && (i_peripAddr == STAT_ADDR)) ? status : 8'h00;
      o_irq            <= empty && (state == IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      o_tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          baud <= '0;
          if (pop) begin
            shreg   <= head;
            par_bit <= ^head;
            o_tx    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            o_tx    <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              o_tx  <= par_bit;
              state <= PARITY;
`else
              o_tx  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              o_tx    <= shreg[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud  <= '0;
            o_tx  <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shreg   <= head;
              par_bit <= ^head;
              o_tx    <= 1'b0;
              state   <= START;
            end else begin
              o_tx  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          baud  <= '0;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with CLKS_PER_BIT=4; honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_periph;

  localparam int         C    = 4;
  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] STAT = 8'h11;
`ifdef UART_TX_PARITY_EN
  localparam bit         PAR  = 1'b1;
  localparam logic [7:0] PBIT = 8'h10;
`else
  localparam bit         PAR  = 1'b0;
  localparam logic [7:0] PBIT = 8'h00;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wr;
  logic       rd;
  logic [7:0] rdata;
  logic       tx;
  logic       irq;

  int tests = 0;
  int fails = 0;

  uart_tx_periph #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_peripAddr       (addr),
    .i_peripDataFromCPU(wdata),
    .i_peripWrSig      (wr),
    .i_peripRdSig      (rd),
    .o_peripDataToCPU  (rdata),
    .o_tx              (tx),
    .o_irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; addr = 8'h00; wdata = 8'h00;
  endtask

  task automatic bus_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0; addr = 8'h00;
    check(tag, rdata, exp);
  endtask

  // Checks every sample of one frame; returns how many negedges passed before the start bit appeared.
  task automatic expect_frame(input logic [7:0] b, input bit b2b, output int lat);
    logic [10:0] bits;
    logic        obs_bit;
    int          nb;
    lat  = 0;
    nb   = PAR ? 11 : 10;
    bits = PAR ? {1'b1, ^b, b, 1'b0} : {1'b1, 1'b1, b, 1'b0};
    if (b2b) begin
      @(negedge clk);
      check($sformatf("b2b_start_%h", b), {7'b0, tx}, 8'h00);
    end else begin
      while (tx !== 1'b0 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("start_seen_%h", b), {7'b0, tx}, 8'h00);
    end
    for (int i = 0; i < nb; i++) begin
      obs_bit = bits[i];
      for (int k = 0; k < C; k++) begin
        if (i > 0 || k > 0) @(negedge clk);
        if (tx !== bits[i]) obs_bit = tx;
      end
      check($sformatf("frame_%h_bit%0d", b, i), {7'b0, obs_bit}, {7'b0, bits[i]});
    end
  endtask

  // Called on the last stop-bit sample: irq is still low one cycle later, high the cycle after.
  task automatic expect_irq_rise(input string tag);
    @(negedge clk);
    check({tag, "_irq_low"}, {7'b0, irq}, 8'h00);
    check({tag, "_tx_idle"}, {7'b0, tx}, 8'h01);
    @(negedge clk);
    check({tag, "_irq_high"}, {7'b0, irq}, 8'h01);
  endtask

  initial begin
    int  lat;
    int  n;
    bit  bad;
    rst = 1'b0; addr = 8'h00; wdata = 8'h00; wr = 1'b0; rd = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_tx", {7'b0, tx}, 8'h01);
    check("rst_rdata", rdata, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle status and unmapped / data-register reads
    bus_read("stat_idle", STAT, 8'h04 | PBIT);
    @(negedge clk);
    check("rdata_clears", rdata, 8'h00);
    bus_read("read_unmapped", 8'h00, 8'h00);
    bus_read("read_datareg", BASE, 8'h00);

    // Single frame of 8'hA5
    bus_write(BASE, 8'hA5);
    expect_frame(8'hA5, 1'b0, lat);
    check("start_latency", 8'(lat), 8'd1);
    expect_irq_rise("a5");

    // Two writes on consecutive cycles -> back-to-back frames
    @(negedge clk);
    wr = 1'b1; addr = BASE; wdata = 8'h01;
    @(negedge clk);
    wdata = 8'h02;
    @(negedge clk);
    wr = 1'b0; addr = 8'h00; wdata = 8'h00;
    expect_frame(8'h01, 1'b0, lat);
    expect_frame(8'h02, 1'b1, lat);
    expect_irq_rise("b2b");

    // Overflow: fill FIFO while 8'h11 is on the line, fifth queued write is dropped
    bus_write(BASE, 8'h11);
    fork
      begin
        expect_frame(8'h11, 1'b0, lat);
        expect_frame(8'h22, 1'b1, lat);
        expect_frame(8'h33, 1'b1, lat);
        expect_frame(8'h44, 1'b1, lat);
        expect_frame(8'h55, 1'b1, lat);
      end
      begin
        bus_write(BASE, 8'h22);
        bus_write(BASE, 8'h33);
        bus_write(BASE, 8'h44);
        bus_write(BASE, 8'h55);
        bus_write(BASE, 8'h66);
        bus_read("stat_full_ovf", STAT, 8'h0B | PBIT);
        bus_write(STAT, 8'hFF);
        bus_read("stat_ovf_clear", STAT, 8'h03 | PBIT);
      end
    join
    expect_irq_rise("ovf");
    bad = 1'b0;
    for (int i = 0; i < 12 * C; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    check("dropped_not_sent", {7'b0, bad}, 8'h00);
    bus_read("stat_drained", STAT, 8'h04 | PBIT);

    // Asynchronous reset in the middle of the data bits
    bus_write(BASE, 8'h5A);
    n = 0;
    while (tx !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (C + 1) @(negedge clk);
    check("pre_reset_tx", {7'b0, tx}, 8'h00);
    #1 rst = 1'b0;
    #1;
    check("async_rst_tx", {7'b0, tx}, 8'h01);
    check("async_rst_irq", {7'b0, irq}, 8'h01);
    check("async_rst_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_read("stat_after_rst", STAT, 8'h04 | PBIT);
    bus_write(BASE, 8'hC3);
    expect_frame(8'hC3, 1'b0, lat);
    expect_irq_rise("post_rst");

    // 8'h07: parity bit is 1 when parity framing is built in
    bus_write(BASE, 8'h07);
    expect_frame(8'h07, 1'b0, lat);
    expect_irq_rise("p07");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
